// File: rtl/register_file_scan.sv
// Register file with two combinational read ports, one clocked write port, and a debug scan port.
// Latency: reads are combinational, writes land at the next edge, scan beats start one cycle after scan_start.
// Backpressure: a scan beat is held, address and data unchanged, until scan_ready; writes and reads are never blocked.
module register_file_scan #(
    parameter int WIDTH     = 64,
    parameter int ADDR_BITS = 5,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     D,
    input  logic [ADDR_BITS-1:0] DA,
    input  logic                 write,
    input  logic [ADDR_BITS-1:0] SA,
    input  logic [ADDR_BITS-1:0] SB,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    input  logic                 scan_start,
    output logic                 scan_busy,
    output logic                 scan_valid,
    input  logic                 scan_ready,
    output logic [ADDR_BITS-1:0] scan_addr,
    output logic [WIDTH-1:0]     scan_data,
    output logic                 scan_last
);

    localparam int                   DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST  = '1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } scan_state_t;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic                 wr_en;
    logic                 a_is_zero;
    logic                 b_is_zero;

    scan_state_t          state_q;
    scan_state_t          state_d;
    logic [ADDR_BITS-1:0] addr_q;
    logic [ADDR_BITS-1:0] addr_d;
    logic [WIDTH-1:0]     data_q;
    logic [WIDTH-1:0]     data_d;
    logic [ADDR_BITS-1:0] load_addr;
    logic [WIDTH-1:0]     load_val;
    logic                 handshake;

    assign wr_en     = write && !((ZERO_REG != 0) && (DA == LAST));
    assign a_is_zero = (ZERO_REG != 0) && (SA == LAST);
    assign b_is_zero = (ZERO_REG != 0) && (SB == LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[DA] <= D;
        end
    end

    // Zero register wins over bypass so a write aimed at it never leaks through.
    always_comb begin
        A = mem[SA];
        if ((BYPASS != 0) && write && (DA == SA)) begin
            A = D;
        end
        if (a_is_zero) begin
            A = '0;
        end
    end

    always_comb begin
        B = mem[SB];
        if ((BYPASS != 0) && write && (DA == SB)) begin
            B = D;
        end
        if (b_is_zero) begin
            B = '0;
        end
    end

    // Snapshot path reads the array directly: pre-write contents, never bypassed.
    assign load_addr = (state_q == IDLE) ? '0 : addr_q + ADDR_BITS'(1);
    assign load_val  = ((ZERO_REG != 0) && (load_addr == LAST)) ? '0 : mem[load_addr];
    assign handshake = (state_q == SEND) && scan_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (scan_start) begin
                    state_d = SEND;
                    addr_d  = '0;
                    data_d  = load_val;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (addr_q == LAST) begin
                        state_d = IDLE;
                    end else begin
                        addr_d = load_addr;
                        data_d = load_val;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign scan_valid = (state_q == SEND);
    assign scan_busy  = (state_q == SEND);
    assign scan_addr  = addr_q;
    assign scan_data  = data_q;
    assign scan_last  = scan_valid && (addr_q == LAST);

endmodule

// File: tb/tb_register_file_scan.sv
// Directed bench: default file, a no-bypass twin sharing its inputs, and a small 16x8 file.
module tb_register_file_scan;

    logic        clock;
    logic        reset;
    logic [63:0] d;
    logic [4:0]  da;
    logic        write;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [63:0] a0, b0, a1, b1;
    logic        scan_start, scan_ready;
    logic        busy0, valid0, last0, busy1, valid1, last1;
    logic [4:0]  saddr0, saddr1;
    logic [63:0] sdata0, sdata1;

    logic [15:0] c_d;
    logic [2:0]  c_da, c_sa, c_sb;
    logic        c_write, c_start, c_ready;
    logic [15:0] c_a, c_b, c_data;
    logic        c_busy, c_valid, c_last;
    logic [2:0]  c_addr;

    int checks = 0;
    int errors = 0;

    register_file_scan u_dut (
        .clock(clock), .reset(reset), .D(d), .DA(da), .write(write), .SA(sa), .SB(sb),
        .A(a0), .B(b0), .scan_start(scan_start), .scan_busy(busy0), .scan_valid(valid0),
        .scan_ready(scan_ready), .scan_addr(saddr0), .scan_data(sdata0), .scan_last(last0)
    );

    register_file_scan #(.BYPASS(0)) u_nobyp (
        .clock(clock), .reset(reset), .D(d), .DA(da), .write(write), .SA(sa), .SB(sb),
        .A(a1), .B(b1), .scan_start(scan_start), .scan_busy(busy1), .scan_valid(valid1),
        .scan_ready(scan_ready), .scan_addr(saddr1), .scan_data(sdata1), .scan_last(last1)
    );

    register_file_scan #(.WIDTH(16), .ADDR_BITS(3), .ZERO_REG(0)) u_small (
        .clock(clock), .reset(reset), .D(c_d), .DA(c_da), .write(c_write), .SA(c_sa), .SB(c_sb),
        .A(c_a), .B(c_b), .scan_start(c_start), .scan_busy(c_busy), .scan_valid(c_valid),
        .scan_ready(c_ready), .scan_addr(c_addr), .scan_data(c_data), .scan_last(c_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; d = '0; da = '0; write = 1'b0; sa = '0; sb = '0;
        scan_start = 1'b0; scan_ready = 1'b0;
        c_d = '0; c_da = '0; c_write = 1'b0; c_sa = '0; c_sb = '0; c_start = 1'b0; c_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_valid", 64'(valid0), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_last", 64'(last0), 64'd0);
        chk("rst_addr", 64'(saddr0), 64'd0);
        chk("rst_data", sdata0, 64'd0);
        chk("rst_a", a0, 64'd0);

        // Basic write then read on both ports.
        da = 5'd3; d = 64'hDEADBEEF_00000001; write = 1'b1;
        tick();
        write = 1'b0; sa = 5'd3; sb = 5'd3;
        #1;
        chk("rd3_a", a0, 64'hDEADBEEF_00000001);
        chk("rd3_b", b0, 64'hDEADBEEF_00000001);
        sa = 5'd4; sb = 5'd0;
        #1;
        chk("rd4_a", a0, 64'd0);
        chk("rd0_b", b0, 64'd0);

        // Zero register ignores writes.
        da = 5'd31; d = 64'hFFFF; write = 1'b1;
        tick();
        write = 1'b0; sa = 5'd31;
        #1;
        chk("zero_a", a0, 64'd0);

        // Same-cycle bypass vs no-bypass twin; bypass never reaches the zero register.
        da = 5'd7; d = 64'h55; write = 1'b1; sa = 5'd7;
        #1;
        chk("byp_a", a0, 64'h55);
        chk("nobyp_a_same", a1, 64'd0);
        tick();
        write = 1'b0;
        #1;
        chk("nobyp_a_next", a1, 64'h55);
        da = 5'd31; d = 64'h77; write = 1'b1; sb = 5'd31;
        #1;
        chk("zero_nobyp_b", b0, 64'd0);
        write = 1'b0;

        // Preload reg[i] = i+100 and stream the whole file.
        for (int i = 0; i < 31; i++) begin
            da = 5'(i); d = 64'(i + 100); write = 1'b1;
            tick();
        end
        write = 1'b0;
        scan_start = 1'b1; scan_ready = 1'b1;
        tick();
        scan_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            #1;
            chk("full_valid", 64'(valid0), 64'd1);
            chk("full_addr", 64'(saddr0), 64'(i));
            chk("full_data", sdata0, (i == 31) ? 64'd0 : 64'(i + 100));
            chk("full_last", 64'(last0), (i == 31) ? 64'd1 : 64'd0);
            tick();
        end
        #1;
        chk("full_busy_after", 64'(busy0), 64'd0);
        chk("full_valid_after", 64'(valid0), 64'd0);

        // Stall at addr 5 with a write to the presented register.
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        repeat (5) tick();
        scan_ready = 1'b0; da = 5'd5; d = 64'h999; write = 1'b1;
        #1;
        chk("stall_addr0", 64'(saddr0), 64'd5);
        chk("stall_data0", sdata0, 64'd105);
        tick();
        write = 1'b0; sa = 5'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_addr", 64'(saddr0), 64'd5);
            chk("stall_data", sdata0, 64'd105);
            chk("stall_valid", 64'(valid0), 64'd1);
            tick();
        end
        chk("stall_wr_visible", a0, 64'h999);
        // Handshake at 5 while writing reg 6: the beat for 6 carries the old value.
        scan_ready = 1'b1; da = 5'd6; d = 64'h666; write = 1'b1;
        tick();
        write = 1'b0;
        #1;
        chk("snap_addr6", 64'(saddr0), 64'd6);
        chk("snap_data6", sdata0, 64'd106);
        repeat (4) tick();
        chk("mid_addr10", 64'(saddr0), 64'd10);

        // Reset mid-scan.
        reset = 1'b1;
        tick();
        reset = 1'b0; sa = 5'd5; sb = 5'd30;
        #1;
        chk("mrst_valid", 64'(valid0), 64'd0);
        chk("mrst_busy", 64'(busy0), 64'd0);
        chk("mrst_a", a0, 64'd0);
        chk("mrst_b", b0, 64'd0);
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            #1;
            chk("zscan_addr", 64'(saddr0), 64'(i));
            chk("zscan_data", sdata0, 64'd0);
            chk("zscan_last", 64'(last0), (i == 31) ? 64'd1 : 64'd0);
            tick();
        end
        #1;
        chk("zscan_busy_after", 64'(busy0), 64'd0);

        // Small 16-bit, 8-entry file without a zero register.
        c_da = 3'd7; c_d = 16'hA5A5; c_write = 1'b1;
        tick();
        c_write = 1'b0; c_sa = 3'd7; c_sb = 3'd2;
        #1;
        chk("small_a7", 64'(c_a), 64'hA5A5);
        chk("small_b2", 64'(c_b), 64'd0);
        c_start = 1'b1; c_ready = 1'b1;
        tick();
        c_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("small_addr", 64'(c_addr), 64'(i));
            chk("small_data", 64'(c_data), (i == 7) ? 64'hA5A5 : 64'd0);
            chk("small_last", 64'(c_last), (i == 7) ? 64'd1 : 64'd0);
            tick();
        end
        #1;
        chk("small_busy_after", 64'(c_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
